// File: rtl/sap_cpu.sv
// Parametrised SAP-style CPU: PC, IR, A, B, C/Z flags, output register and a five-state sequencer.
// Optional macro SAP_OUT_HANDSHAKE_EN adds out_ready and makes OUT stall until the transfer is accepted.
module sap_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
`ifdef SAP_OUT_HANDSHAKE_EN
  input  logic              out_ready,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              is_sub;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   sum;
  logic              unused_ok;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  // B is loaded for architectural visibility; the ALU uses the memory word directly.
  assign unused_ok = ^{ir_q, b_q};

  // SUB is A + ~M + 1 so carry out means "no borrow".
  assign is_sub = (opcode == 4'h3);
  assign alu_b  = is_sub ? ~mem_rdata : mem_rdata;
  assign sum    = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};

  assign mem_addr  = (state_q == S_EXEC || state_q == S_MEM) ? operand : pc_q;
  assign mem_wdata = a_q;
  assign mem_we    = (state_q == S_EXEC) && (opcode == 4'h4) && !rst;
  assign halted    = (state_q == S_HALT);

`ifdef SAP_OUT_HANDSHAKE_EN
  assign out_valid = (state_q == S_EXEC) && (opcode == 4'hE);
  assign out_data  = out_valid ? a_q : out_data_q;
`else
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          4'h1, 4'h2, 4'h3: state_d = S_MEM;
          4'h5: a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
          4'h6: pc_d = operand;
          4'h7: if (c_q) pc_d = operand;
          4'h8: if (z_q) pc_d = operand;
          4'hE: begin
`ifdef SAP_OUT_HANDSHAKE_EN
            if (out_ready) out_data_d = a_q;
            else           state_d    = S_EXEC;
`else
            out_data_d  = a_q;
            out_valid_d = 1'b1;
`endif
          end
          4'hF: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        b_d     = mem_rdata;
        state_d = S_FETCH;
        if (opcode == 4'h1) begin
          a_d = mem_rdata;
        end else begin
          a_d = sum[DATA_W-1:0];
          c_d = sum[DATA_W];
          z_d = (sum[DATA_W-1:0] == '0);
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
